usbdev_aon_wake_mp: RTL

Multi-port, parametrised always-on USB wake detector. It runs in the AON clock domain next to the usbdev core and handles up to NumPorts independent USB links. For each suspended link it holds the pull-up state, monitors the bus for resume, bus reset, VBUS loss or a programmable suspend timeout, and raises a wake request until the core acknowledges it.

---
 rtl/usbdev_aon_wake_mp_if.sv | 42 ++++
 rtl/usbdev_aon_wake_mp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/usbdev_aon_wake_mp_if.sv
// Signal bundle between the AON wake detector and its surroundings.
// The master side drives pins and requests; the slave side is the detector.
interface usbdev_aon_wake_mp_if #(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned TimeoutW = 16
);
    logic [NumPorts-1:0] usb_dp_i;
    logic [NumPorts-1:0] usb_dn_i;
    logic [NumPorts-1:0] usb_sense_i;
    logic [NumPorts-1:0] usbdev_dppullup_en_i;
    logic [NumPorts-1:0] usbdev_dnpullup_en_i;
    logic [NumPorts-1:0] suspend_req_aon_i;
    logic [NumPorts-1:0] wake_ack_aon_i;
    logic [TimeoutW-1:0] timeout_limit_i;
    logic [NumPorts-1:0] usb_dppullup_en_o;
    logic [NumPorts-1:0] usb_dnpullup_en_o;
    logic                wake_req_aon_o;
    logic [NumPorts-1:0] wake_port_aon_o;
    logic [NumPorts-1:0] bus_not_idle_aon_o;
    logic [NumPorts-1:0] bus_reset_aon_o;
    logic [NumPorts-1:0] sense_lost_aon_o;
    logic [NumPorts-1:0] timeout_aon_o;
    logic [NumPorts-1:0] wake_detect_active_aon_o;

    modport master (
        output usb_dp_i, usb_dn_i, usb_sense_i,
        output usbdev_dppullup_en_i, usbdev_dnpullup_en_i,
        output suspend_req_aon_i, wake_ack_aon_i, timeout_limit_i,
        input  usb_dppullup_en_o, usb_dnpullup_en_o, wake_req_aon_o, wake_port_aon_o,
        input  bus_not_idle_aon_o, bus_reset_aon_o, sense_lost_aon_o, timeout_aon_o,
        input  wake_detect_active_aon_o
    );

    modport slave (
        input  usb_dp_i, usb_dn_i, usb_sense_i,
        input  usbdev_dppullup_en_i, usbdev_dnpullup_en_i,
        input  suspend_req_aon_i, wake_ack_aon_i, timeout_limit_i,
        output usb_dppullup_en_o, usb_dnpullup_en_o, wake_req_aon_o, wake_port_aon_o,
        output bus_not_idle_aon_o, bus_reset_aon_o, sense_lost_aon_o, timeout_aon_o,
        output wake_detect_active_aon_o
    );
endinterface

// File: rtl/usbdev_aon_wake_mp.sv
// Multi-port always-on USB wake detector: per-port pin conditioning, pull-up hold
// and an IDLE/ARMED/WOKEN FSM that raises a wake request until acknowledged.

// Counter filter: output follows the input only after Cycles consecutive differing samples.
module usbdev_aon_wake_mp_filter #(
    parameter int unsigned Cycles = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw != filt) begin
            if (cnt == CntW'(Cycles - 1)) begin
                filt <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CntW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

module usbdev_aon_wake_mp #(
    parameter int unsigned NumPorts          = 2,
    parameter int unsigned FilterCycles      = 4,
    parameter int unsigned ResetFilterCycles = 3,
    parameter int unsigned TimeoutW          = 16
) (
    input logic                 clk_aon_i,
    input logic                 rst_aon_i,
    usbdev_aon_wake_mp_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, WOKEN = 2'd2} state_t;

    logic [NumPorts-1:0] dppu_pad, dnpu_pad, wake, active;
    logic [NumPorts-1:0] flag_ni, flag_se0, flag_sl, flag_to;

    for (genvar g = 0; g < NumPorts; g++) begin : g_port
        state_t              state;
        logic [4:0]          sync1, sync2;
        logic                held_dp, held_dn, pad_dp, pad_dn;
        logic [TimeoutW-1:0] cnt;
        logic [3:0]          flags;
        logic                wake_q, active_q;
        logic                ni_raw, se0_raw, sl_raw, ni_filt, se0_filt, sl_filt;
        logic                timeout_hit;
        logic [3:0]          evt;

        // Two-flop synchroniser for {dp, dn, sense, dp pull-up, dn pull-up}.
        always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
            if (rst_aon_i) begin
                sync1 <= '0;
                sync2 <= '0;
            end else begin
                sync1 <= {bus.usb_dp_i[g], bus.usb_dn_i[g], bus.usb_sense_i[g],
                          bus.usbdev_dppullup_en_i[g], bus.usbdev_dnpullup_en_i[g]};
                sync2 <= sync1;
            end
        end

        // Passthrough while idle so the core keeps direct control of its pull-ups.
        assign pad_dp = (state == IDLE) ? bus.usbdev_dppullup_en_i[g] : held_dp;
        assign pad_dn = (state == IDLE) ? bus.usbdev_dnpullup_en_i[g] : held_dn;

        assign ni_raw  = (sync2[4] != pad_dp) | (sync2[3] != pad_dn);
        assign se0_raw = ~sync2[4] & ~sync2[3];
        assign sl_raw  = ~sync2[2];

        usbdev_aon_wake_mp_filter #(.Cycles(FilterCycles)) u_ni_filt (
            .clk(clk_aon_i), .rst(rst_aon_i), .raw(ni_raw), .filt(ni_filt)
        );
        usbdev_aon_wake_mp_filter #(.Cycles(ResetFilterCycles)) u_se0_filt (
            .clk(clk_aon_i), .rst(rst_aon_i), .raw(se0_raw), .filt(se0_filt)
        );
        usbdev_aon_wake_mp_filter #(.Cycles(ResetFilterCycles)) u_sl_filt (
            .clk(clk_aon_i), .rst(rst_aon_i), .raw(sl_raw), .filt(sl_filt)
        );

        assign timeout_hit = (bus.timeout_limit_i != '0) && (cnt == bus.timeout_limit_i);
        assign evt         = {1'b0, sl_filt, se0_filt, ni_filt};

        // Port FSM; wake_ack is checked first so it wins over same-cycle events.
        always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
            if (rst_aon_i) begin
                state    <= IDLE;
                held_dp  <= 1'b0;
                held_dn  <= 1'b0;
                cnt      <= '0;
                flags    <= '0;
                wake_q   <= 1'b0;
                active_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        held_dp <= sync2[1];
                        held_dn <= sync2[0];
                        cnt     <= '0;
                        flags   <= '0;
                        wake_q  <= 1'b0;
                        if (bus.suspend_req_aon_i[g]) begin
                            state    <= ARMED;
                            active_q <= 1'b1;
                        end
                    end
                    ARMED, WOKEN: begin
                        if (bus.wake_ack_aon_i[g]) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            flags    <= '0;
                            wake_q   <= 1'b0;
                            active_q <= 1'b0;
                        end else begin
                            if (cnt != '1) cnt <= cnt + TimeoutW'(1);
                            if (state == ARMED) begin
                                flags <= flags | evt | {timeout_hit, 3'b000};
                                if ((|evt) || timeout_hit) begin
                                    state  <= WOKEN;
                                    wake_q <= 1'b1;
                                end
                            end else begin
                                flags <= flags | evt;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        wake_q   <= 1'b0;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end

        assign dppu_pad[g] = pad_dp;
        assign dnpu_pad[g] = pad_dn;
        assign wake[g]     = wake_q;
        assign active[g]   = active_q;
        assign flag_ni[g]  = flags[0];
        assign flag_se0[g] = flags[1];
        assign flag_sl[g]  = flags[2];
        assign flag_to[g]  = flags[3];
    end

    assign bus.usb_dppullup_en_o        = dppu_pad;
    assign bus.usb_dnpullup_en_o        = dnpu_pad;
    assign bus.wake_port_aon_o          = wake;
    assign bus.wake_req_aon_o           = |wake;
    assign bus.bus_not_idle_aon_o       = flag_ni;
    assign bus.bus_reset_aon_o          = flag_se0;
    assign bus.sense_lost_aon_o         = flag_sl;
    assign bus.timeout_aon_o            = flag_to;
    assign bus.wake_detect_active_aon_o = active;
endmodule
